// File: rtl/cache_pkg.sv
// Shared constants and directory-entry type for the 4-way set-associative cache.
package cache_pkg;

  localparam int NUM_WAYS = 4;
  localparam int AGE_BITS = 2;
  localparam logic [AGE_BITS-1:0] AGE_MAX = 2'd3;
  // Way 0 starts oldest and way 3 youngest, so the first fills walk ways 0..3.
  localparam logic [NUM_WAYS*AGE_BITS-1:0] AGE_RESET = 8'b00_01_10_11;

  localparam int ADDR_BITS = 32;
  localparam int OFF_BITS  = 4;
  localparam int IDX_BITS  = 6;
  localparam int TAG_BITS  = ADDR_BITS - OFF_BITS - IDX_BITS;
  localparam int NUM_SETS  = 1 << IDX_BITS;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic                valid;
    logic                dirty;
  } dir_entry_t;

endpackage

// File: rtl/cache_victim_select.sv
// Replacement choice for one set: lowest invalid way, else lowest way at max age, else way 0.
module cache_victim_select
  import cache_pkg::*;
(
  input  logic [NUM_WAYS-1:0]          valid,
  input  logic [NUM_WAYS*AGE_BITS-1:0] ages,
  output logic [NUM_WAYS-1:0]          victim
);

  // Scanning downward lets the lowest qualifying way overwrite higher ones.
  always_comb begin
    victim    = '0;
    victim[0] = 1'b1;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (ages[w*AGE_BITS +: AGE_BITS] == AGE_MAX) begin
        victim    = '0;
        victim[w] = 1'b1;
      end
    end
    if (!(&valid)) begin
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
        if (!valid[w]) begin
          victim    = '0;
          victim[w] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_tag_lru.sv
// Tag directory and LRU age store; CACHE_WRITEBACK_EN enables dirty tracking and eviction reporting.
module cache_tag_lru
  import cache_pkg::*;
#(
  parameter int ADDRESS_WORD_SIZE = ADDR_BITS,
  parameter int OFFSET_BITS       = OFF_BITS,
  parameter int INDEX_BITS        = IDX_BITS
) (
  input  logic                                              clk,
  input  logic                                              rst_b,
  input  logic [ADDRESS_WORD_SIZE-1:0]                      address_word,
  input  logic                                              try_read,
  input  logic                                              try_write,
  input  logic [NUM_WAYS-1:0]                               reset_age,
  input  logic [NUM_WAYS-1:0]                               increment_age,
  output logic                                              hit_miss,
  output logic [NUM_WAYS-1:0]                               hit_miss_set,
  output logic [NUM_WAYS*AGE_BITS-1:0]                      ages,
  output logic                                              evict_dirty,
  output logic [ADDRESS_WORD_SIZE-OFFSET_BITS-INDEX_BITS-1:0] evict_tag
);

  localparam int TAG_W = ADDRESS_WORD_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int SETS  = 1 << INDEX_BITS;

  // Entry width comes from cache_pkg, so address-split overrides must be mirrored there.
  dir_entry_t                   dir_q [SETS][NUM_WAYS];
  logic [NUM_WAYS*AGE_BITS-1:0] age_q [SETS];
  logic [INDEX_BITS-1:0]        idx_q;

  logic [INDEX_BITS-1:0]        req_idx;
  logic [TAG_W-1:0]             req_tag;
  logic                         lookup;
  logic                         age_upd;
  logic [NUM_WAYS-1:0]          valid_vec;
  logic [NUM_WAYS-1:0]          match_vec;
  logic [NUM_WAYS-1:0]          hit_onehot;
  logic [NUM_WAYS-1:0]          victim;
  logic [NUM_WAYS*AGE_BITS-1:0] upd_ages;
  logic                         hit;
  logic                         fill_dirty;
  logic                         unused_offset;

  assign req_idx       = address_word[OFFSET_BITS +: INDEX_BITS];
  assign req_tag       = address_word[ADDRESS_WORD_SIZE-1 -: TAG_W];
  assign unused_offset = &{1'b0, address_word[OFFSET_BITS-1:0]};
  assign lookup        = try_read | try_write;
  assign age_upd       = (|reset_age) | (|increment_age);
  assign ages          = age_q[idx_q];
  assign hit           = |match_vec;

  always_comb begin
    valid_vec  = '0;
    match_vec  = '0;
    hit_onehot = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = dir_q[req_idx][w].valid;
      match_vec[w] = dir_q[req_idx][w].valid && (dir_q[req_idx][w].tag == req_tag);
    end
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (match_vec[w]) begin
        hit_onehot    = '0;
        hit_onehot[w] = 1'b1;
      end
    end
  end

  cache_victim_select u_victim (
    .valid  (valid_vec),
    .ages   (age_q[req_idx]),
    .victim (victim)
  );

  // Reset wins over increment; increment saturates rather than wrapping.
  always_comb begin
    upd_ages = age_q[idx_q];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (reset_age[w]) begin
        upd_ages[w*AGE_BITS +: AGE_BITS] = '0;
      end else if (increment_age[w] && (upd_ages[w*AGE_BITS +: AGE_BITS] != AGE_MAX)) begin
        upd_ages[w*AGE_BITS +: AGE_BITS] = upd_ages[w*AGE_BITS +: AGE_BITS] + 2'd1;
      end
    end
  end

`ifdef CACHE_WRITEBACK_EN
  dir_entry_t victim_entry;

  assign fill_dirty = try_write;

  always_comb begin
    victim_entry = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (victim[w]) victim_entry = dir_q[req_idx][w];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      evict_dirty <= 1'b0;
      evict_tag   <= '0;
    end else if (lookup) begin
      evict_dirty <= !hit && victim_entry.valid && victim_entry.dirty;
      evict_tag   <= hit ? '0 : victim_entry.tag;
    end
  end
`else
  assign fill_dirty  = 1'b0;
  assign evict_dirty = 1'b0;
  assign evict_tag   = '0;
`endif

  // Age update targets the index held before this edge; the lookup then re-latches it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= AGE_RESET;
        for (int w = 0; w < NUM_WAYS; w++) dir_q[s][w] <= '0;
      end
      idx_q        <= '0;
      hit_miss     <= 1'b0;
      hit_miss_set <= '0;
    end else begin
      if (age_upd) age_q[idx_q] <= upd_ages;
      if (lookup) begin
        idx_q        <= req_idx;
        hit_miss     <= hit;
        hit_miss_set <= hit ? hit_onehot : victim;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (!hit && victim[w]) begin
            dir_q[req_idx][w] <= '{tag: req_tag, valid: 1'b1, dirty: fill_dirty};
          end
`ifdef CACHE_WRITEBACK_EN
          else if (hit && hit_onehot[w] && try_write) begin
            dir_q[req_idx][w].dirty <= 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_lru.sv
// Directed self-checking bench for cache_tag_lru; evict checks follow CACHE_WRITEBACK_EN.
module tb_cache_tag_lru;
  import cache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_b;
  logic [31:0]           address_word;
  logic                  try_read;
  logic                  try_write;
  logic [3:0]            reset_age;
  logic [3:0]            increment_age;
  logic                  hit_miss;
  logic [3:0]            hit_miss_set;
  logic [7:0]            ages;
  logic                  evict_dirty;
  logic [TAG_BITS-1:0]   evict_tag;

  int vectors     = 0;
  int miscompares = 0;

  cache_tag_lru dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .address_word  (address_word),
    .try_read      (try_read),
    .try_write     (try_write),
    .reset_age     (reset_age),
    .increment_age (increment_age),
    .hit_miss      (hit_miss),
    .hit_miss_set  (hit_miss_set),
    .ages          (ages),
    .evict_dirty   (evict_dirty),
    .evict_tag     (evict_tag)
  );

  always #5 clk = ~clk;

  // One clock with the given request and age strobes, then back to idle 1 ns after the edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [3:0] rst_age, input logic [3:0] inc_age);
    address_word  = addr;
    try_read      = rd;
    try_write     = wr;
    reset_age     = rst_age;
    increment_age = inc_age;
    @(posedge clk);
    #1;
    try_read      = 1'b0;
    try_write     = 1'b0;
    reset_age     = 4'b0000;
    increment_age = 4'b0000;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkLookup(input string tag, input logic exp_hit, input logic [3:0] exp_set);
    checkOutput({tag, "_hit"}, {31'd0, hit_miss}, {31'd0, exp_hit});
    checkOutput({tag, "_set"}, {28'd0, hit_miss_set}, {28'd0, exp_set});
  endtask

  initial begin
    rst_b         = 1'b0;
    address_word  = '0;
    try_read      = 1'b0;
    try_write     = 1'b0;
    reset_age     = 4'b0000;
    increment_age = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkLookup("reset", 1'b0, 4'b0000);
    checkOutput("reset_ages", {24'd0, ages}, 32'h1B);
    checkOutput("reset_evd", {31'd0, evict_dirty}, 32'd0);
    checkOutput("reset_evt", {10'd0, evict_tag}, 32'd0);
    rst_b = 1'b1;

    applyStimulus(32'h0000_1230, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("first_miss", 1'b0, 4'b0001);
    checkOutput("first_ages", {24'd0, ages}, 32'h1B);
    checkOutput("first_evd", {31'd0, evict_dirty}, 32'd0);

    applyStimulus(32'h0000_1230, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("reread_hit", 1'b1, 4'b0001);

    @(posedge clk);
    #1;
    checkLookup("idle_hold", 1'b1, 4'b0001);

    applyStimulus(32'h0000_1630, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("fill_t5", 1'b0, 4'b0010);
    applyStimulus(32'h0000_1A30, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("fill_t6", 1'b0, 4'b0100);
    applyStimulus(32'h0000_1E30, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("fill_t7", 1'b0, 4'b1000);

    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0001, 4'b1110);
    checkOutput("age_step1", {24'd0, ages}, 32'h6C);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0001, 4'b1110);
    checkOutput("age_step2", {24'd0, ages}, 32'hBC);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0001, 4'b1110);
    checkOutput("age_step3", {24'd0, ages}, 32'hFC);

    applyStimulus(32'h0000_2230, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("lru_victim_w1", 1'b0, 4'b0010);
    checkOutput("lru_evd", {31'd0, evict_dirty}, 32'd0);

    applyStimulus(32'h0000_1230, 1'b0, 1'b1, 4'b0000, 4'b0000);
    checkLookup("write_hit_t4", 1'b1, 4'b0001);
    checkOutput("write_hit_evd", {31'd0, evict_dirty}, 32'd0);

    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b0001);
    checkOutput("way0_aged", {24'd0, ages}, 32'hFF);

    applyStimulus(32'h0000_2630, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("evict_w0", 1'b0, 4'b0001);
`ifdef CACHE_WRITEBACK_EN
    checkOutput("evict_dirty", {31'd0, evict_dirty}, 32'd1);
    checkOutput("evict_tag", {10'd0, evict_tag}, 32'h4);
`else
    checkOutput("evict_dirty_wt", {31'd0, evict_dirty}, 32'd0);
    checkOutput("evict_tag_wt", {10'd0, evict_tag}, 32'd0);
`endif

    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    checkOutput("age_saturate", {24'd0, ages}, 32'hFF);
    applyStimulus(32'h0, 1'b0, 1'b0, 4'b0100, 4'b0100);
    checkOutput("reset_beats_inc", {24'd0, ages}, 32'hCF);

    applyStimulus(32'h0000_2230, 1'b1, 1'b0, 4'b0000, 4'b0100);
    checkLookup("same_idx_upd", 1'b1, 4'b0010);
    checkOutput("same_idx_ages", {24'd0, ages}, 32'hDF);

    applyStimulus(32'h0000_0040, 1'b1, 1'b0, 4'b0001, 4'b0000);
    checkLookup("new_idx_miss", 1'b0, 4'b0001);
    checkOutput("new_idx_ages", {24'd0, ages}, 32'h1B);

    applyStimulus(32'h0000_1E30, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("old_idx_hit_t7", 1'b1, 4'b1000);
    checkOutput("old_idx_ages", {24'd0, ages}, 32'hDC);

    #2;
    rst_b = 1'b0;
    #1;
    checkLookup("midreset", 1'b0, 4'b0000);
    checkOutput("midreset_ages", {24'd0, ages}, 32'h1B);
    checkOutput("midreset_evd", {31'd0, evict_dirty}, 32'd0);
    checkOutput("midreset_evt", {10'd0, evict_tag}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    applyStimulus(32'h0000_2230, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("post_reset_miss", 1'b0, 4'b0001);
    applyStimulus(32'h0000_1E30, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkLookup("post_reset_miss2", 1'b0, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
